tone_period_detector: RTL



---
 rtl/tone_pkg.sv | 17 +
 rtl/zero_cross_hyst.sv | 62 ++++++
 rtl/tone_period_detector.sv | 113 +++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone receive path.
package tone_pkg;

    typedef enum logic [1:0] {
        POL_UNKNOWN = 2'd0,
        POL_LOW     = 2'd1,
        POL_HIGH    = 2'd2
    } polarity_t;

    typedef enum logic {
        TRK_SEARCH  = 1'b0,
        TRK_MEASURE = 1'b1
    } tracker_t;

    localparam int unsigned SAMPLE_RATE_HZ = 12000;

endpackage

// File: rtl/zero_cross_hyst.sv
// Hysteresis polarity tracker; flags a rising zero crossing when the signal
// leaves a qualified LOW state by reaching +HYST_THRESH.
module zero_cross_hyst
    import tone_pkg::*;
#(
    parameter int HYST_THRESH = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       step_in,
    input  logic [7:0] sample_in,
    output logic       rise_event,
    output logic [1:0] polarity
);

    // 9-bit signed compares keep -128 and -HYST_THRESH representable.
    localparam logic signed [8:0] POS_TH = 9'(HYST_THRESH);
    localparam logic signed [8:0] NEG_TH = -9'(HYST_THRESH);

    polarity_t        pol_q;
    polarity_t        pol_d;
    logic signed [8:0] sample_ext;
    logic             at_high;
    logic             at_low;

    assign sample_ext = $signed({sample_in[7], sample_in});
    assign at_high    = (sample_ext >= POS_TH);
    assign at_low     = (sample_ext <= NEG_TH);

    // Next polarity and rise event, evaluated only on sample strobes.
    always_comb begin
        pol_d      = pol_q;
        rise_event = 1'b0;
        if (step_in) begin
            unique case (pol_q)
                POL_UNKNOWN: begin
                    if (at_high)     pol_d = POL_HIGH;
                    else if (at_low) pol_d = POL_LOW;
                end
                POL_LOW: begin
                    if (at_high) begin
                        pol_d      = POL_HIGH;
                        rise_event = 1'b1;
                    end
                end
                POL_HIGH: begin
                    if (at_low) pol_d = POL_LOW;
                end
                default: pol_d = POL_UNKNOWN;
            endcase
        end
    end

    // Polarity register.
    always_ff @(posedge clk_in) begin
        if (rst_in) pol_q <= POL_UNKNOWN;
        else        pol_q <= pol_d;
    end

    assign polarity = pol_q;

endmodule

// File: rtl/tone_period_detector.sv
// Measures tone period between hysteresis-qualified rising zero crossings,
// sums 2^LOG2_AVG periods per report and tracks tone presence.
module tone_period_detector
    import tone_pkg::*;
#(
    parameter int HYST_THRESH = 4,
    parameter int LOG2_AVG    = 2,
    parameter int MIN_PERIOD  = 4,
    parameter int MAX_PERIOD  = 255,
    parameter int CNT_W       = $clog2(MAX_PERIOD + 2),
    parameter int PERIOD_W    = CNT_W + LOG2_AVG
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                step_in,
    input  logic [7:0]          sample_in,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid_out,
    output logic                tone_present_out
);

    localparam int N_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [N_W-1:0]   N_LAST  = N_W'((1 << LOG2_AVG) - 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PERIOD);

    logic                rise_event;
    logic [1:0]          polarity;
    logic                rise_ok;
    logic                accept;

    tracker_t            state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PERIOD_W-1:0] acc_q;
    logic [N_W-1:0]      n_q;
    logic [PERIOD_W-1:0] period_q;
    logic                valid_q;
    logic                present_q;

    zero_cross_hyst #(
        .HYST_THRESH (HYST_THRESH)
    ) u_zc (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .step_in    (step_in),
        .sample_in  (sample_in),
        .rise_event (rise_event),
        .polarity   (polarity)
    );

    // A rise can only originate from the LOW state; the gate is redundant with
    // the tracker but keeps the event tied to its source polarity.
    assign rise_ok = rise_event && (polarity_t'(polarity) == POL_LOW);
    assign accept  = rise_ok && (cnt_q >= CNT_MIN);

    // Period tracker FSM with counter, accumulator and registered outputs.
    // An accepted rise is tested before the timeout so cnt == MAX_PERIOD
    // still yields a valid measurement.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= TRK_SEARCH;
            cnt_q     <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (step_in) begin
                unique case (state_q)
                    TRK_SEARCH: begin
                        if (rise_ok) begin
                            state_q <= TRK_MEASURE;
                            cnt_q   <= CNT_W'(1);
                            acc_q   <= '0;
                            n_q     <= '0;
                        end
                    end
                    TRK_MEASURE: begin
                        if (accept) begin
                            cnt_q <= CNT_W'(1);
                            if (n_q == N_LAST) begin
                                period_q  <= acc_q + PERIOD_W'(cnt_q);
                                valid_q   <= 1'b1;
                                present_q <= 1'b1;
                                acc_q     <= '0;
                                n_q       <= '0;
                            end else begin
                                acc_q <= acc_q + PERIOD_W'(cnt_q);
                                n_q   <= n_q + N_W'(1);
                            end
                        end else if (cnt_q == CNT_MAX) begin
                            state_q   <= TRK_SEARCH;
                            present_q <= 1'b0;
                            acc_q     <= '0;
                            n_q       <= '0;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= TRK_SEARCH;
                endcase
            end
        end
    end

    assign period_out       = period_q;
    assign period_valid_out = valid_q;
    assign tone_present_out = present_q;

endmodule
